// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall controller for the five-stage pipeline: tracks E/M destination shadows
// and the mult/div busy counter, and decides whether the D-stage instruction advances.
module pipe_stall_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_dst,
    input  logic [1:0] d_tnew,
    input  logic       d_md_start,
    input  logic       d_md_div,
    input  logic       d_md_use,
    output logic       stall,
    output logic       pc_en,
    output logic       fd_en,
    output logic       de_clr,
    output logic       md_busy
);

    typedef enum logic {
        MD_IDLE,
        MD_BUSY
    } md_state_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    logic [4:0] e_dst, m_dst, e_dst_nxt, m_dst_nxt;
    logic [1:0] e_tnew, m_tnew, e_tnew_nxt, m_tnew_nxt;
    logic [3:0] md_cnt, md_cnt_nxt;
    md_state_t  md_state;
    logic       stall_rs, stall_rt, stall_md;

    function automatic logic src_hazard(
        input logic [4:0] r,
        input logic [1:0] tuse,
        input logic [4:0] ed,
        input logic [1:0] et,
        input logic [4:0] md,
        input logic [1:0] mt
    );
        return (r != 5'd0) && (((ed == r) && (et > tuse)) || ((md == r) && (mt > tuse)));
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            e_dst  <= '0;
            e_tnew <= '0;
            m_dst  <= '0;
            m_tnew <= '0;
            md_cnt <= '0;
        end else begin
            e_dst  <= e_dst_nxt;
            e_tnew <= e_tnew_nxt;
            m_dst  <= m_dst_nxt;
            m_tnew <= m_tnew_nxt;
            md_cnt <= md_cnt_nxt;
        end
    end

    always_comb begin
        md_state   = (md_cnt != 4'd0) ? MD_BUSY : MD_IDLE;
        stall_rs   = src_hazard(d_rs, d_tuse_rs, e_dst, e_tnew, m_dst, m_tnew);
        stall_rt   = src_hazard(d_rt, d_tuse_rt, e_dst, e_tnew, m_dst, m_tnew);
        stall_md   = d_md_use && (md_state == MD_BUSY);
        // Outputs are forced idle while reset is held, whatever the stored state.
        stall      = reset && (stall_rs || stall_rt || stall_md);

        m_dst_nxt  = e_dst;
        m_tnew_nxt = (e_tnew == 2'd0) ? 2'd0 : e_tnew - 2'd1;
        e_dst_nxt  = stall ? 5'd0 : d_dst;
        e_tnew_nxt = stall ? 2'd0 : d_tnew;

        md_cnt_nxt = md_cnt;
        if (!stall && d_md_start) begin
            md_cnt_nxt = d_md_div ? DIV_LOAD : MULT_LOAD;
        end else begin
            case (md_state)
                MD_BUSY: md_cnt_nxt = md_cnt - 4'd1;
                default: md_cnt_nxt = md_cnt;
            endcase
        end
    end

    assign pc_en   = ~stall;
    assign fd_en   = ~stall;
    assign de_clr  = stall;
    assign md_busy = reset && (md_state == MD_BUSY);

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed hazard scenarios plus random traffic, checked
// against an age-based model of in-flight instructions and mult/div issue times.
module tb_pipe_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] d_rs, d_rt, d_dst;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_md_start, d_md_div, d_md_use;
    logic       stall, pc_en, fd_en, de_clr, md_busy;

    int checks = 0;
    int errors = 0;

    pipe_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_dst(d_dst), .d_tnew(d_tnew),
        .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
        .stall(stall), .pc_en(pc_en), .fd_en(fd_en), .de_clr(de_clr), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    // Model: queue of instructions that left D, newest first; index k is k+1 stages past D.
    typedef struct {
        logic [4:0] dst;
        logic [1:0] tnew;
    } slot_t;
    slot_t pipe[$];
    int    cyc      = 0;
    int    md_issue = 0;
    int    md_len   = 0;

    function automatic bit model_hazard(logic [4:0] r, logic [1:0] tuse);
        if (r == 5'd0) return 1'b0;
        for (int k = 0; k < pipe.size() && k < 2; k++) begin
            if (pipe[k].dst == r && (int'(pipe[k].tnew) - k) > int'(tuse)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit model_busy();
        return (md_len != 0) && (cyc > md_issue) && (cyc <= md_issue + md_len);
    endfunction

    function automatic bit model_stall();
        if (!reset) return 1'b0;
        return model_hazard(d_rs, d_tuse_rs) || model_hazard(d_rt, d_tuse_rt) ||
               (d_md_use && model_busy());
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (cycle %0d): observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [1:0] tur,
                         input logic [4:0] rt, input logic [1:0] tut,
                         input logic [4:0] dst, input logic [1:0] tnew,
                         input logic mds, input logic mdd, input logic mdu);
        d_rs = rs; d_tuse_rs = tur; d_rt = rt; d_tuse_rt = tut;
        d_dst = dst; d_tnew = tnew;
        d_md_start = mds; d_md_div = mdd; d_md_use = mdu;
    endtask

    task automatic nop();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // One clock: check outputs mid-cycle, then advance the model across the edge.
    task automatic step(output logic s_obs);
        logic exp_s, exp_b;
        slot_t sl;
        @(negedge clk);
        exp_s = model_stall();
        exp_b = reset && model_busy();
        check_bit("stall", stall, exp_s);
        check_bit("pc_en", pc_en, ~exp_s);
        check_bit("fd_en", fd_en, ~exp_s);
        check_bit("de_clr", de_clr, exp_s);
        check_bit("md_busy", md_busy, exp_b);
        s_obs = stall;
        @(posedge clk);
        if (!reset) begin
            pipe.delete();
            md_len = 0;
        end else begin
            sl.dst  = exp_s ? 5'd0 : d_dst;
            sl.tnew = exp_s ? 2'd0 : d_tnew;
            pipe.push_front(sl);
            if (pipe.size() > 2) void'(pipe.pop_back());
            if (!exp_s && d_md_start) begin
                md_issue = cyc;
                md_len   = d_md_div ? 10 : 5;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic run_until_free(output int n);
        logic s;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            step(s);
            if (!s) break;
            n++;
        end
    endtask

    initial begin
        logic s;
        int   n;
        reset = 1'b0;
        nop();
        #1;
        for (int i = 0; i < 3; i++) step(s);
        reset = 1'b1;

        // Load-use on rs: exactly one bubble.
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd2, 1'b0, 1'b0, 1'b0);
        step(s);
        drive(5'd8, 2'd1, 5'd0, 2'd3, 5'd3, 2'd1, 1'b0, 1'b0, 1'b0);
        run_until_free(n);
        check_int("load_use_stalls", n, 1);

        // Branch after load: two bubbles.
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd9, 2'd2, 1'b0, 1'b0, 1'b0);
        step(s);
        drive(5'd0, 2'd3, 5'd9, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        run_until_free(n);
        check_int("branch_load_stalls", n, 2);

        // ALU result feeding a branch: one bubble.
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd7, 2'd1, 1'b0, 1'b0, 1'b0);
        step(s);
        drive(5'd7, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        run_until_free(n);
        check_int("branch_alu_stalls", n, 1);

        // $0 destination and Tuse 3 never stall.
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
        step(s);
        drive(5'd0, 2'd0, 5'd0, 2'd3, 5'd4, 2'd1, 1'b0, 1'b0, 1'b0);
        run_until_free(n);
        check_int("reg0_stalls", n, 0);
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd10, 2'd2, 1'b0, 1'b0, 1'b0);
        step(s);
        drive(5'd10, 2'd3, 5'd10, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        run_until_free(n);
        check_int("tuse3_stalls", n, 0);

        // div then mflo: ten stall cycles.
        drive(5'd2, 2'd1, 5'd3, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
        step(s);
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'd1, 1'b0, 1'b0, 1'b1);
        run_until_free(n);
        check_int("div_stalls", n, 10);
        nop();
        step(s);

        // mult then mflo: five stall cycles.
        drive(5'd2, 2'd1, 5'd3, 2'd1, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1);
        step(s);
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'd1, 1'b0, 1'b0, 1'b1);
        run_until_free(n);
        check_int("mult_stalls", n, 5);

        // Back-to-back mult: second waits 5, then reloads a full 5.
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1);
        step(s);
        run_until_free(n);
        check_int("mult2_wait", n, 5);
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'd1, 1'b0, 1'b0, 1'b1);
        run_until_free(n);
        check_int("mult2_busy", n, 5);

        // Reset with div in flight at md_cnt=6.
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
        step(s);
        nop();
        for (int i = 0; i < 4; i++) step(s);
        check_bit("busy_before_reset", md_busy, 1'b1);
        reset = 1'b0;
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'd1, 1'b0, 1'b0, 1'b1);
        #1;
        check_bit("busy_in_reset", md_busy, 1'b0);
        check_bit("stall_in_reset", stall, 1'b0);
        step(s);
        reset = 1'b1;
        run_until_free(n);
        check_int("mflo_after_reset", n, 0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic mds;
            mds = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 79) != 0);
            drive(5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 7)), 2'($urandom_range(0, 2)),
                  mds, 1'($urandom_range(0, 1)),
                  mds || ($urandom_range(0, 5) == 0));
            step(s);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Hazard and stall controller for the five-stage MIPS pipeline. It sits beside the F/D, D/E and E/M pipeline registers and decides, each cycle, whether the D-stage instruction may advance. It keeps its own shadow of the destination register and Tnew for the instructions in E and M. It also runs the mult/div busy counter that blocks HI/LO accesses. Outputs drive the PC enable, the F/D register enable and the D/E register clear. The E/M register is never stalled.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu, counted from the cycle the op is in E
- DIV_CYCLES, 10, busy cycles for div/divu; must be ≤ 15

- clk  in  1  pipeline clock, all state updates on posedge
- reset  in  1  synchronous, active-low: state clears on a posedge where reset==0
- d_rs  in  5  rs field of the D-stage instruction
- d_rt  in  5  rt field of the D-stage instruction
- d_tuse_rs  in  2  Tuse for rs: 0 = needed in D, 1 = needed in E, 2 = needed in M, 3 = unused
- d_tuse_rt  in  2  Tuse for rt, same encoding as d_tuse_rs
- d_dst  in  5  destination GPR of the D-stage instruction; 0 means no write
- d_tnew  in  2  cycles after entering E until the result is forwardable: 0 = jal/lui-class, 1 = ALU, 2 = load
- d_md_start  in  1  the D-stage instruction is mult/multu/div/divu
- d_md_div  in  1  qualifies d_md_start: 1 = div/divu
- d_md_use  in  1  the D-stage instruction is mfhi/mflo/mthi/mtlo/mult/multu/div/divu
- stall  out  1  the D-stage instruction is held this cycle
- pc_en  out  1  equals ~stall
- fd_en  out  1  equals ~stall
- de_clr  out  1  equals stall; the D/E register loads a bubble
- md_busy  out  1  the mult/div unit is occupied (md_cnt != 0)

## Operation
- Shadow state: e_dst[4:0] and e_tnew[1:0] describe the instruction in E; m_dst[4:0] and m_tnew[1:0] describe the instruction in M. Instructions in W are treated as Tnew 0 and never cause a stall.
- Per-source hazard check, shown for rs: stall_rs = (d_rs != 0) && ((e_dst == d_rs && e_tnew > d_tuse_rs) || (m_dst == d_rs && m_tnew > d_tuse_rs)). stall_rt is the same check using rt.
- Tuse 3 can never stall, because Tnew is at most 2.
- stall_md = d_md_use && (md_cnt != 0).
- stall = stall_rs | stall_rt | stall_md.
- Shadow update every posedge:
  - m_dst ← e_dst
  - m_tnew ← e_tnew - 1, saturating at 0
  - if stall: e_dst ← 0 and e_tnew ← 0 (bubble)
  - else: e_dst ← d_dst and e_tnew ← d_tnew
- md_cnt[3:0] counter states: IDLE (md_cnt == 0) and BUSY (md_cnt != 0).
  - Load: if !stall && d_md_start, md_cnt ← (d_md_div ? DIV_CYCLES : MULT_CYCLES).
  - Otherwise, if md_cnt != 0, md_cnt ← md_cnt - 1.
  - Load and decrement cannot coincide: d_md_start implies d_md_use, so a start is stalled while the unit is BUSY.
- A mult/div op is in E in the first cycle md_cnt is nonzero.

## Timing
- Reset (posedge with reset==0): e_dst, e_tnew, m_dst, m_tnew and md_cnt all go to 0.
- Outputs while reset==0: stall=0, pc_en=1, fd_en=1, de_clr=0, md_busy=0, regardless of state.
- stall, pc_en, fd_en and de_clr are combinational from the current state and the D inputs. There is zero latency from a D-input change to a stall decision.
- md_busy is derived only from the register (md_cnt != 0).
- Load-use (load in E, consumer has Tuse 1): exactly 1 stall cycle.
- Load in E, consumer has Tuse 0 (branch): 2 stall cycles.
- ALU result in E, consumer has Tuse 0: 1 stall cycle.
- mult entering E: a following HI/LO op is stalled for MULT_CYCLES cycles. div: DIV_CYCLES cycles. The HI/LO op advances in the cycle md_cnt reads 0.
- Reset mid-operation: a BUSY counter and pending hazards are discarded; the next cycle is stall-free.

## Test plan
- Load-use on rs:
  - Stimulus: cycle 0 D: lw $8 (d_dst=8, d_tnew=2). Cycle 1 D: add with d_rs=8, d_tuse_rs=1.
  - Required: stall=1, de_clr=1, pc_en=0 in cycle 1 only; stall=0 in cycle 2.
- Branch after load:
  - Stimulus: lw $9 followed by beq with d_rt=9, d_tuse_rt=0.
  - Required: stall=1 for 2 consecutive cycles, then 0.
- $0 and unused operands:
  - Stimulus: lw $0 followed by a consumer with d_rs=0 and d_tuse_rs=0; separately, a consumer with d_tuse=3 matching e_dst.
  - Required: stall=0 in both cases.
- div busy:
  - Stimulus: div advances (d_md_div=1); the next instruction is mflo (d_md_use=1).
  - Required: md_busy=1 and stall=1 for 10 cycles, then stall=0 and md_busy=0.
  - Repeat with mult: 5 stall cycles.
- Back-to-back mult:
  - Stimulus: mult followed by mult.
  - Required: the second mult stalls 5 cycles, then loads md_cnt=5 with no lost or extra cycle.
- Reset mid-busy:
  - Stimulus: div in flight with md_cnt=6; drive reset=0 for one posedge, then release.
  - Required: md_busy=0 and stall=0 while reset==0 and afterwards; an mflo issued next proceeds without stalling.
